pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Parametrised fetch-stage program counter with stall, flush, branch/trap redirect and a
//  one-entry pending-redirect buffer. Sits at the head of the pipelined CPU and feeds the
//  instruction memory address and IF/ID register. It holds a redirect that arrives while
//  StallF is high, so no taken branch or trap is lost.
// PARAMETERS
//  XLEN          32     PC width in bits
//  RESET_VECTOR  32'h0  PC value loaded on reset (XLEN wide)
//  INSTR_BYTES   4      sequential increment; power of two; alignment granule
//  BOOT_WAIT     2      cycles after reset release before the first valid fetch (>=1)
// PORTS
//  CLK        in   1     clock; all state updates on rising edge
//  RESET      in   1     asynchronous, active-low reset
//  StallF     in   1     1 = hold PCF (hazard unit)
//  FlushF     in   1     1 = fetch in flight is killed (ValidF=0 next cycle)
//  RedirectE  in   1     taken branch/jump from execute
//  PCTargetE  in   XLEN  branch/jump target
//  TrapReq    in   1     trap/exception request
//  TrapVector in   XLEN  trap handler address
//  PCF        out  XLEN  current fetch address (registered)
//  PCPlusF    out  XLEN  PCF + INSTR_BYTES (combinational, modulo 2^XLEN)
//  ValidF     out  1     1 = PCF is a live fetch
//  PendingF   out  1     1 = redirect buffered, waiting for StallF to drop
//  AlignErr   out  1     one-cycle pulse: accepted target had nonzero low bits
// BEHAVIOUR
//  Reset (RESET=0, immediate, any state): PCF=RESET_VECTOR, ValidF=0, PendingF=0,
//   AlignErr=0, pending target=0, boot counter=0, state=BOOT.
//  FSM states: BOOT, RUN, HOLD.
//   BOOT: PCF held at RESET_VECTOR, ValidF=0. Counter increments every cycle and ignores
//    StallF, FlushF, RedirectE and TrapReq. After BOOT_WAIT cycles it goes to RUN.
//    ValidF=1 on the first RUN cycle. PCF advances on the first RUN edge with StallF=0.
//   RUN, StallF=0: PCF <= next. Next-PC priority:
//    TrapVector > PCTargetE > PCPlusF. ValidF <= ~FlushF.
//   RUN, StallF=1: PCF and ValidF held. If TrapReq or RedirectE: the target is latched,
//    PendingF <= 1, and the state goes to HOLD. Latched source: trap if both are asserted.
//   HOLD, StallF=1: PCF held. A new TrapReq overwrites the latched target. A new RedirectE
//    replaces it only if the latched target is not a trap.
//   HOLD, StallF=0: PCF <= TrapVector if TrapReq, else PCTargetE if RedirectE, else the
//    latched target. PendingF <= 0. ValidF <= ~FlushF. State goes to RUN.
//  Latency: redirect seen with StallF=0 reaches PCF on the next edge (1 cycle). A buffered
//   redirect reaches PCF on the edge where StallF is first sampled 0.
//  Alignment: every accepted target has its low log2(INSTR_BYTES) bits forced to 0.
//   AlignErr=1 for exactly the cycle after a target with nonzero low bits is accepted into
//   PCF or the buffer; it is 0 otherwise.
//  Wrap: PCPlusF and sequential advance are modulo 2^XLEN, so the all-ones aligned PC
//   advances to 0.
//  FlushF with StallF=1: ValidF is still held (stall wins). Flush takes effect on release.
//  PendingF=1 implies state HOLD. ValidF never rises during BOOT.
// TESTING
//  1 Reset/boot: RESET=0 for 3 cycles, release, StallF=0 -> PCF=0,ValidF=0 for 2 cycles,
//    then ValidF=1, PCF=0,4,8,...
//  2 Stall: StallF=1 at PCF=0x10 for 3 cycles -> PCF stays 0x10. Release -> 0x14.
//  3 Buffered branch: at PCF=0x20, StallF=1, RedirectE=1 pulse, target 0x80 -> PendingF=1,
//    PCF=0x20. Release -> PCF=0x80, PendingF=0.
//  4 Priority: TrapReq=1 (0x100) with RedirectE=1 (0x80) in the same cycle, StallF=0 ->
//    PCF=0x100. Repeat under stall: buffered target is 0x100, and a later RedirectE does
//    not overwrite it.
//  5 Misalign/wrap: target 0x43 -> PCF=0x40, AlignErr pulses 1 cycle. PCF=0xFFFFFFFC
//    sequential -> 0x00000000.
//  6 Async reset mid-HOLD (PendingF=1) between clock edges -> all outputs at reset values
//    immediately. Buffered target is discarded after release.

Source files
------------

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage control bundle: hazard/execute/trap
// requests in, fetch address and status out.
interface pc_fetch_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            StallF;
  logic            FlushF;
  logic            RedirectE;
  logic [XLEN-1:0] PCTargetE;
  logic            TrapReq;
  logic [XLEN-1:0] TrapVector;
  logic [XLEN-1:0] PCF;
  logic [XLEN-1:0] PCPlusF;
  logic            ValidF;
  logic            PendingF;
  logic            AlignErr;

  modport master (
    output StallF,
    output FlushF,
    output RedirectE,
    output PCTargetE,
    output TrapReq,
    output TrapVector,
    input  PCF,
    input  PCPlusF,
    input  ValidF,
    input  PendingF,
    input  AlignErr
  );

  modport slave (
    input  StallF,
    input  FlushF,
    input  RedirectE,
    input  PCTargetE,
    input  TrapReq,
    input  TrapVector,
    output PCF,
    output PCPlusF,
    output ValidF,
    output PendingF,
    output AlignErr
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC with boot wait, stall/flush, redirect
// priority and a one-entry pending-redirect buffer.
module pc_fetch_ctrl #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INSTR_BYTES  = 4,
  parameter int unsigned     BOOT_WAIT    = 2
) (
  input logic            CLK,
  input logic            RESET,
  pc_fetch_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(BOOT_WAIT + 1);
  localparam logic [XLEN-1:0] LOWM =
    XLEN'(INSTR_BYTES - 1);
  localparam logic [XLEN-1:0] INC =
    XLEN'(INSTR_BYTES);
  localparam logic [CW-1:0] LAST =
    CW'(BOOT_WAIT - 1);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] tgt_q;
  logic            ptrap_q;
  logic            valid_q;
  logic            pend_q;
  logic            aerr_q;

  logic            req;
  logic [XLEN-1:0] tgt_raw;
  logic [XLEN-1:0] tgt_al;
  logic            tgt_mis;
  logic [XLEN-1:0] pc_plus;
  logic            ovr;

  always_comb begin
    req     = bus.TrapReq | bus.RedirectE;
    tgt_raw = bus.TrapReq ? bus.TrapVector
                          : bus.PCTargetE;
    tgt_al  = tgt_raw & ~LOWM;
    tgt_mis = |(tgt_raw & LOWM);
    pc_plus = pc_q + INC;
    // A buffered trap may only be replaced by a trap
    ovr     = bus.TrapReq |
              (bus.RedirectE & ~ptrap_q);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      pc_q    <= RESET_VECTOR;
      tgt_q   <= '0;
      ptrap_q <= 1'b0;
      valid_q <= 1'b0;
      pend_q  <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      aerr_q <= 1'b0;
      unique case (state_q)
        BOOT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            state_q <= RUN;
            valid_q <= 1'b1;
          end
        end
        RUN: begin
          if (!bus.StallF) begin
            pc_q    <= req ? tgt_al : pc_plus;
            valid_q <= ~bus.FlushF;
            aerr_q  <= req & tgt_mis;
          end else if (req) begin
            tgt_q   <= tgt_al;
            ptrap_q <= bus.TrapReq;
            pend_q  <= 1'b1;
            aerr_q  <= tgt_mis;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (!bus.StallF) begin
            pc_q    <= req ? tgt_al : tgt_q;
            valid_q <= ~bus.FlushF;
            aerr_q  <= req & tgt_mis;
            pend_q  <= 1'b0;
            ptrap_q <= 1'b0;
            state_q <= RUN;
          end else if (ovr) begin
            tgt_q   <= tgt_al;
            ptrap_q <= bus.TrapReq;
            aerr_q  <= tgt_mis;
          end
        end
        default: begin
          state_q <= BOOT;
        end
      endcase
    end
  end

  assign bus.PCF      = pc_q;
  assign bus.PCPlusF  = pc_plus;
  assign bus.ValidF   = valid_q;
  assign bus.PendingF = pend_q;
  assign bus.AlignErr = aerr_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: expected
// fetch state is queued per step and checked after the edge.
module tb_pc_fetch_ctrl;

  logic CLK;
  logic RESET;

  pc_fetch_ctrl_if #(.XLEN(32)) bus ();

  pc_fetch_ctrl #(
    .XLEN        (32),
    .RESET_VECTOR(32'h0),
    .INSTR_BYTES (4),
    .BOOT_WAIT   (2)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        v;
    logic        p;
    logic        a;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input logic st,
                       input logic fl,
                       input logic br,
                       input logic [31:0] bt,
                       input logic tr,
                       input logic [31:0] tv);
    bus.StallF     = st;
    bus.FlushF     = fl;
    bus.RedirectE  = br;
    bus.PCTargetE  = bt;
    bus.TrapReq    = tr;
    bus.TrapVector = tv;
  endtask

  task automatic check_now(input string tag,
                           input logic [31:0] pc,
                           input logic v,
                           input logic p,
                           input logic a);
    chk({tag, ".pc"}, bus.PCF, pc);
    chk({tag, ".pcplus"}, bus.PCPlusF, pc + 32'd4);
    chk({tag, ".valid"}, 32'(bus.ValidF), 32'(v));
    chk({tag, ".pend"}, 32'(bus.PendingF), 32'(p));
    chk({tag, ".aerr"}, 32'(bus.AlignErr), 32'(a));
  endtask

  // Push expectation, clock once, pop and compare.
  task automatic step(input string tag,
                      input logic [31:0] pc,
                      input logic v,
                      input logic p,
                      input logic a);
    exp_t e;
    e.tag = tag;
    e.pc  = pc;
    e.v   = v;
    e.p   = p;
    e.a   = a;
    sbq.push_back(e);
    @(posedge CLK);
    #1;
    if (sbq.size() == 0) begin
      chk({tag, ".sbq_empty"}, 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      check_now(e.tag, e.pc, e.v, e.p, e.a);
    end
  endtask

  initial begin
    RESET = 1'b0;
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    repeat (3) @(posedge CLK);
    #1;
    check_now("reset", 32'h0, 0, 0, 0);

    // Boot wait, then sequential fetch
    RESET = 1'b1;
    step("boot1", 32'h0, 0, 0, 0);
    step("boot2", 32'h0, 1, 0, 0);
    step("seq4", 32'h4, 1, 0, 0);
    step("seq8", 32'h8, 1, 0, 0);
    step("seqC", 32'hC, 1, 0, 0);
    step("seq10", 32'h10, 1, 0, 0);

    // Plain stall
    drive(1, 0, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 3; i++)
      step("stall", 32'h10, 1, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    step("unstall", 32'h14, 1, 0, 0);
    step("seq18", 32'h18, 1, 0, 0);
    step("seq1C", 32'h1C, 1, 0, 0);
    step("seq20", 32'h20, 1, 0, 0);

    // Buffered branch
    drive(1, 0, 1, 32'h80, 0, 32'h0);
    step("buf_br", 32'h20, 1, 1, 0);
    drive(1, 0, 0, 32'h0, 0, 32'h0);
    step("buf_hold", 32'h20, 1, 1, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    step("buf_rel", 32'h80, 1, 0, 0);
    step("seq84", 32'h84, 1, 0, 0);

    // Trap beats branch, unstalled and buffered
    drive(0, 0, 1, 32'h80, 1, 32'h100);
    step("prio", 32'h100, 1, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    step("seq104", 32'h104, 1, 0, 0);
    drive(1, 0, 1, 32'h80, 1, 32'h100);
    step("prio_buf", 32'h104, 1, 1, 0);
    drive(1, 0, 1, 32'h200, 0, 32'h0);
    step("no_ovr", 32'h104, 1, 1, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    step("prio_rel", 32'h100, 1, 0, 0);

    // Flush under stall is held, applies on release
    drive(1, 1, 0, 32'h0, 0, 32'h0);
    step("flush_st", 32'h100, 1, 0, 0);
    drive(0, 1, 0, 32'h0, 0, 32'h0);
    step("flush", 32'h104, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    step("unflush", 32'h108, 1, 0, 0);

    // Misaligned targets, direct and buffered
    drive(0, 0, 1, 32'h43, 0, 32'h0);
    step("mis", 32'h40, 1, 0, 1);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    step("mis_clr", 32'h44, 1, 0, 0);
    drive(1, 0, 0, 32'h0, 1, 32'h102);
    step("mis_buf", 32'h44, 1, 1, 1);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    step("mis_rel", 32'h100, 1, 0, 0);

    // Wrap at top of address space
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0);
    step("top", 32'hFFFF_FFFC, 1, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    step("wrap", 32'h0, 1, 0, 0);

    // Async reset while a redirect is buffered
    drive(1, 0, 1, 32'h80, 0, 32'h0);
    step("pre_rst", 32'h0, 1, 1, 0);
    drive(1, 0, 0, 32'h0, 0, 32'h0);
    #3;
    RESET = 1'b0;
    #1;
    check_now("async_rst", 32'h0, 0, 0, 0);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    drive(0, 0, 0, 32'h0, 0, 32'h0);
    step("reboot1", 32'h0, 0, 0, 0);
    step("reboot2", 32'h0, 1, 0, 0);
    step("no_stale", 32'h4, 1, 0, 0);

    chk("sbq_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
